// File: rtl/alu_issue_decode_pkg.sv
// Shared definitions for the ALU issue/decode block: one-hot bit indices,
// MIPS opcode/funct encodings, buffer state type and the decoded issue record.
package alu_defs;

    // One-hot bit positions of the 12-bit ALU control vector
    localparam int unsigned ALU_ADD_BIT  = 11;
    localparam int unsigned ALU_SUB_BIT  = 10;
    localparam int unsigned ALU_SLT_BIT  = 9;
    localparam int unsigned ALU_SLTU_BIT = 8;
    localparam int unsigned ALU_AND_BIT  = 7;
    localparam int unsigned ALU_NOR_BIT  = 6;
    localparam int unsigned ALU_OR_BIT   = 5;
    localparam int unsigned ALU_XOR_BIT  = 4;
    localparam int unsigned ALU_SLL_BIT  = 3;
    localparam int unsigned ALU_SRL_BIT  = 2;
    localparam int unsigned ALU_SRA_BIT  = 1;
    localparam int unsigned ALU_LUI_BIT  = 0;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Decoded instruction as it travels through the skid buffer (83 bits)
    typedef struct packed {
        logic [11:0] control;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  dest;
        logic        wen;
        logic        illegal;
    } alu_issue_t;

    // Skid buffer occupancy
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } buf_state_e;

    function automatic logic [11:0] alu_onehot(input int unsigned idx);
        logic [11:0] one;
        one = 12'd1;
        return one << idx;
    endfunction

endpackage

// File: rtl/alu_issue_decode_if.sv
// Handshake bundle between register read (master) and the issue/decode block
// (slave); the slave also drives the decoded ALU-side outputs.
interface alu_issue_decode_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_rs_value;
    logic [31:0] in_rt_value;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_alu_control;
    logic [31:0] out_alu_src1;
    logic [31:0] out_alu_src2;
    logic [4:0]  out_dest;
    logic        out_wen;
    logic        out_illegal;
    logic [15:0] illegal_count;

    modport master (
        output in_valid, in_inst, in_rs_value, in_rt_value, out_ready,
        input  in_ready, out_valid, out_alu_control, out_alu_src1, out_alu_src2,
               out_dest, out_wen, out_illegal, illegal_count
    );

    modport slave (
        input  in_valid, in_inst, in_rs_value, in_rt_value, out_ready,
        output in_ready, out_valid, out_alu_control, out_alu_src1, out_alu_src2,
               out_dest, out_wen, out_illegal, illegal_count
    );
endinterface

// File: rtl/alu_issue_decode_op_decoder.sv
// Purely combinational MIPS integer-ALU decoder: (inst, rs, rt) -> alu_issue_t.
// Optional feature macro: ALU_DECODE_VARSHIFT_EN enables sllv/srlv/srav.
module alu_op_decoder
    import alu_defs::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    output alu_issue_t  issue
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [4:0]  shamt;
    logic [15:0] imm;

    assign opcode = inst[31:26];
    assign rt_idx = inst[20:16];
    assign rd_idx = inst[15:11];
    assign shamt  = inst[10:6];
    assign funct  = inst[5:0];
    assign imm    = inst[15:0];

    logic        legal;
    logic [11:0] ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dest;

    // Select operation, operands and destination; illegal encodings zero everything
    always_comb begin
        legal = 1'b1;
        ctrl  = '0;
        src1  = rs_value;
        src2  = rt_value;
        dest  = rd_idx;
        issue = '0;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_ADD, FN_ADDU: ctrl = alu_onehot(ALU_ADD_BIT);
                FN_SUB, FN_SUBU: ctrl = alu_onehot(ALU_SUB_BIT);
                FN_SLT:          ctrl = alu_onehot(ALU_SLT_BIT);
                FN_SLTU:         ctrl = alu_onehot(ALU_SLTU_BIT);
                FN_AND:          ctrl = alu_onehot(ALU_AND_BIT);
                FN_NOR:          ctrl = alu_onehot(ALU_NOR_BIT);
                FN_OR:           ctrl = alu_onehot(ALU_OR_BIT);
                FN_XOR:          ctrl = alu_onehot(ALU_XOR_BIT);
                FN_SLL: begin
                    ctrl = alu_onehot(ALU_SLL_BIT);
                    src1 = {27'b0, shamt};
                end
                FN_SRL: begin
                    ctrl = alu_onehot(ALU_SRL_BIT);
                    src1 = {27'b0, shamt};
                end
                FN_SRA: begin
                    ctrl = alu_onehot(ALU_SRA_BIT);
                    src1 = {27'b0, shamt};
                end
`ifdef ALU_DECODE_VARSHIFT_EN
                FN_SLLV: begin
                    ctrl = alu_onehot(ALU_SLL_BIT);
                    src1 = {27'b0, rs_value[4:0]};
                end
                FN_SRLV: begin
                    ctrl = alu_onehot(ALU_SRL_BIT);
                    src1 = {27'b0, rs_value[4:0]};
                end
                FN_SRAV: begin
                    ctrl = alu_onehot(ALU_SRA_BIT);
                    src1 = {27'b0, rs_value[4:0]};
                end
`endif
                default: legal = 1'b0;
            endcase
        end else begin
            dest = rt_idx;
            case (opcode)
                OP_ADDI, OP_ADDIU: begin
                    ctrl = alu_onehot(ALU_ADD_BIT);
                    src2 = {{16{imm[15]}}, imm};
                end
                OP_SLTI: begin
                    ctrl = alu_onehot(ALU_SLT_BIT);
                    src2 = {{16{imm[15]}}, imm};
                end
                OP_SLTIU: begin
                    ctrl = alu_onehot(ALU_SLTU_BIT);
                    src2 = {{16{imm[15]}}, imm};
                end
                OP_ANDI: begin
                    ctrl = alu_onehot(ALU_AND_BIT);
                    src2 = {16'b0, imm};
                end
                OP_ORI: begin
                    ctrl = alu_onehot(ALU_OR_BIT);
                    src2 = {16'b0, imm};
                end
                OP_XORI: begin
                    ctrl = alu_onehot(ALU_XOR_BIT);
                    src2 = {16'b0, imm};
                end
                OP_LUI: begin
                    ctrl = alu_onehot(ALU_LUI_BIT);
                    src2 = {16'b0, imm};
                end
                default: legal = 1'b0;
            endcase
        end

        if (legal) begin
            issue.control = ctrl;
            issue.src1    = src1;
            issue.src2    = src2;
            issue.dest    = dest;
            issue.wen     = (dest != 5'd0);
            issue.illegal = 1'b0;
        end else begin
            issue.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_decode.sv
// ALU issue stage: decodes MIPS integer instructions and holds them in a
// 2-entry skid buffer so the ALU can stall without dropping work.
// Optional feature macro: ALU_DECODE_VARSHIFT_EN (handled in alu_op_decoder).
module alu_issue_decode
    import alu_defs::*;
(
    input  logic                clk,
    input  logic                resetn,
    alu_issue_decode_if.slave   bus
);

    alu_issue_t dec;
    alu_issue_t head_q, head_d;
    alu_issue_t tail_q, tail_d;
    buf_state_e state_q, state_d;
    logic       in_ready_q;
    logic       out_valid;
    logic       accept;
    logic       pop;
    logic [15:0] cnt_q, cnt_d;

    alu_op_decoder u_op_decoder (
        .inst     (bus.in_inst),
        .rs_value (bus.in_rs_value),
        .rt_value (bus.in_rt_value),
        .issue    (dec)
    );

    assign accept = bus.in_valid && in_ready_q;
    assign pop    = out_valid && bus.out_ready;

    // Buffer occupancy register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy transitions; accept is impossible in StTwo since in_ready is low
    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: if (accept) state_d = StOne;
            StOne: begin
                if (accept && !pop)      state_d = StTwo;
                else if (!accept && pop) state_d = StEmpty;
            end
            StTwo:   if (pop) state_d = StOne;
            default: state_d = StEmpty;
        endcase
    end

    // Outputs decoded from occupancy
    always_comb begin
        out_valid = (state_q != StEmpty);
    end

    // Entry movement: head is always the older entry and drives the outputs
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        case (state_q)
            StEmpty: if (accept) head_d = dec;
            StOne: begin
                if (accept && pop) head_d = dec;
                else if (accept)   tail_d = dec;
            end
            StTwo:   if (pop) head_d = tail_q;
            default: ;
        endcase
    end

    // Entry storage
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // in_ready registered from next occupancy so it never depends on out_ready in-cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= (state_d != StTwo);
        end
    end

    // Saturating count of accepted illegal instructions
    always_comb begin
        cnt_d = cnt_q;
        if (accept && dec.illegal && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid;
    assign bus.out_alu_control = head_q.control;
    assign bus.out_alu_src1    = head_q.src1;
    assign bus.out_alu_src2    = head_q.src2;
    assign bus.out_dest        = head_q.dest;
    assign bus.out_wen         = head_q.wen;
    assign bus.out_illegal     = head_q.illegal;
    assign bus.illegal_count   = cnt_q;

endmodule

// File: tb/tb_alu_issue_decode.sv
// Directed, table-driven bench for alu_issue_decode.
module tb_alu_issue_decode;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;
    logic [15:0] exp_cnt;

    alu_issue_decode_if bus_if ();

    alu_issue_decode dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [11:0] ctrl;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [4:0]  dest;
        logic        wen;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt);
        bus_if.in_valid    = 1'b1;
        bus_if.in_inst     = inst;
        bus_if.in_rs_value = rs;
        bus_if.in_rt_value = rt;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 16'd0;
        resetn   = 1'b0;
        bus_if.in_valid    = 1'b0;
        bus_if.in_inst     = '0;
        bus_if.in_rs_value = '0;
        bus_if.in_rt_value = '0;
        bus_if.out_ready   = 1'b1;

        //            inst          rs            rt            ctrl    src1          src2          dst wen ill
        vecs.push_back('{32'h00221820, 32'd5,        32'd7,        12'h800, 32'd5,        32'd7,        5'd3, 1'b1, 1'b0});
        vecs.push_back('{32'h2422FFFF, 32'd10,       32'd0,        12'h800, 32'd10,       32'hFFFFFFFF, 5'd2, 1'b1, 1'b0});
        vecs.push_back('{32'h34228000, 32'h000000F0, 32'd0,        12'h020, 32'h000000F0, 32'h00008000, 5'd2, 1'b1, 1'b0});
        vecs.push_back('{32'h000220C0, 32'd99,       32'h10,       12'h008, 32'd3,        32'h10,       5'd4, 1'b1, 1'b0});
        vecs.push_back('{32'h3C051234, 32'd9,        32'd0,        12'h001, 32'd9,        32'h00001234, 5'd5, 1'b1, 1'b0});
        vecs.push_back('{32'h00000000, 32'd1,        32'd2,        12'h008, 32'd0,        32'd2,        5'd0, 1'b0, 1'b0});
        vecs.push_back('{32'h01093822, 32'd100,      32'd30,       12'h400, 32'd100,      32'd30,       5'd7, 1'b1, 1'b0});
        vecs.push_back('{32'h2826FFFE, 32'd4,        32'd0,        12'h200, 32'd4,        32'hFFFFFFFE, 5'd6, 1'b1, 1'b0});
        vecs.push_back('{32'h00430827, 32'h0F0F0F0F, 32'h00FF00FF, 12'h040, 32'h0F0F0F0F, 32'h00FF00FF, 5'd1, 1'b1, 1'b0});
        vecs.push_back('{32'h000517C3, 32'd8,        32'h80000000, 12'h002, 32'd31,       32'h80000000, 5'd2, 1'b1, 1'b0});
        vecs.push_back('{32'h3020FFFF, 32'd3,        32'd0,        12'h080, 32'd3,        32'h0000FFFF, 5'd0, 1'b0, 1'b0});
        vecs.push_back('{32'hFC000000, 32'd11,       32'd12,       12'h000, 32'd0,        32'd0,        5'd0, 1'b0, 1'b1});
        vecs.push_back('{32'h2C238001, 32'd2,        32'd0,        12'h100, 32'd2,        32'hFFFF8001, 5'd3, 1'b1, 1'b0});
        vecs.push_back('{32'h38248001, 32'd2,        32'd0,        12'h010, 32'd2,        32'h00008001, 5'd4, 1'b1, 1'b0});
        vecs.push_back('{32'h00063902, 32'd2,        32'd64,       12'h004, 32'd4,        32'd64,       5'd7, 1'b1, 1'b0});
        vecs.push_back('{32'h0022182B, 32'd1,        32'd2,        12'h100, 32'd1,        32'd2,        5'd3, 1'b1, 1'b0});
        vecs.push_back('{32'h00221824, 32'd1,        32'd2,        12'h080, 32'd1,        32'd2,        5'd3, 1'b1, 1'b0});
        vecs.push_back('{32'h00221825, 32'd1,        32'd2,        12'h020, 32'd1,        32'd2,        5'd3, 1'b1, 1'b0});
        vecs.push_back('{32'h00221826, 32'd1,        32'd2,        12'h010, 32'd1,        32'd2,        5'd3, 1'b1, 1'b0});
        vecs.push_back('{32'h0022182A, 32'd1,        32'd2,        12'h200, 32'd1,        32'd2,        5'd3, 1'b1, 1'b0});
        vecs.push_back('{32'h20220005, 32'd1,        32'd0,        12'h800, 32'd1,        32'd5,        5'd2, 1'b1, 1'b0});
        vecs.push_back('{32'h8C220000, 32'd1,        32'd2,        12'h000, 32'd0,        32'd0,        5'd0, 1'b0, 1'b1});
`ifdef ALU_DECODE_VARSHIFT_EN
        vecs.push_back('{32'h00851804, 32'h25,       32'h77,       12'h008, 32'd5,        32'h77,       5'd3, 1'b1, 1'b0});
`else
        vecs.push_back('{32'h00851804, 32'h25,       32'h77,       12'h000, 32'd0,        32'd0,        5'd0, 1'b0, 1'b1});
`endif

        // Inputs offered during reset must be ignored
        offer(32'h00221820, 32'd1, 32'd2);
        step();
        chk("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        chk("rst_count", {16'd0, bus_if.illegal_count}, 32'd0);
        chk("rst_control", {20'd0, bus_if.out_alu_control}, 32'd0);
        chk("rst_src1", bus_if.out_alu_src1, 32'd0);
        bus_if.in_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        step();

        // Streaming decode, one per cycle with out_ready high
        for (int i = 0; i < vecs.size(); i++) begin
            offer(vecs[i].inst, vecs[i].rs, vecs[i].rt);
            step();
            if (vecs[i].ill) exp_cnt = exp_cnt + 16'd1;
            chk($sformatf("v%0d_valid", i), {31'd0, bus_if.out_valid}, 32'd1);
            chk($sformatf("v%0d_control", i), {20'd0, bus_if.out_alu_control},
                {20'd0, vecs[i].ctrl});
            chk($sformatf("v%0d_src1", i), bus_if.out_alu_src1, vecs[i].src1);
            chk($sformatf("v%0d_src2", i), bus_if.out_alu_src2, vecs[i].src2);
            chk($sformatf("v%0d_dest", i), {27'd0, bus_if.out_dest}, {27'd0, vecs[i].dest});
            chk($sformatf("v%0d_wen", i), {31'd0, bus_if.out_wen}, {31'd0, vecs[i].wen});
            chk($sformatf("v%0d_illegal", i), {31'd0, bus_if.out_illegal},
                {31'd0, vecs[i].ill});
            chk($sformatf("v%0d_count", i), {16'd0, bus_if.illegal_count}, {16'd0, exp_cnt});
        end
        bus_if.in_valid = 1'b0;
        step();
        chk("drain_empty", {31'd0, bus_if.out_valid}, 32'd0);

        // Backpressure: A, B fill the buffer, C waits, then all drain in order
        bus_if.out_ready = 1'b0;
        offer(32'h00221820, 32'd1, 32'd2);       // A: add
        step();
        chk("bp_a_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        chk("bp_a_control", {20'd0, bus_if.out_alu_control}, 32'h800);
        offer(32'h01093822, 32'd3, 32'd4);       // B: sub
        step();
        chk("bp_full_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        offer(32'h3C051234, 32'd6, 32'd0);       // C: lui
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("bp_stall%0d_in_ready", k), {31'd0, bus_if.in_ready}, 32'd0);
            chk($sformatf("bp_stall%0d_valid", k), {31'd0, bus_if.out_valid}, 32'd1);
            chk($sformatf("bp_stall%0d_control", k), {20'd0, bus_if.out_alu_control}, 32'h800);
            chk($sformatf("bp_stall%0d_src1", k), bus_if.out_alu_src1, 32'd1);
            chk($sformatf("bp_stall%0d_src2", k), bus_if.out_alu_src2, 32'd2);
            chk($sformatf("bp_stall%0d_dest", k), {27'd0, bus_if.out_dest}, 32'd3);
        end
        bus_if.out_ready = 1'b1;
        step();
        chk("bp_b_control", {20'd0, bus_if.out_alu_control}, 32'h400);
        chk("bp_b_src1", bus_if.out_alu_src1, 32'd3);
        chk("bp_b_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        step();
        bus_if.in_valid = 1'b0;
        chk("bp_c_control", {20'd0, bus_if.out_alu_control}, 32'h001);
        chk("bp_c_src2", bus_if.out_alu_src2, 32'h00001234);
        chk("bp_c_dest", {27'd0, bus_if.out_dest}, 32'd5);
        step();
        chk("bp_end_valid", {31'd0, bus_if.out_valid}, 32'd0);

        // Asynchronous reset while full
        bus_if.out_ready = 1'b0;
        offer(32'hFC000000, 32'd1, 32'd2);
        step();
        step();
        exp_cnt = exp_cnt + 16'd2;
        chk("full_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        chk("full_count", {16'd0, bus_if.illegal_count}, {16'd0, exp_cnt});
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        chk("arst_count", {16'd0, bus_if.illegal_count}, 32'd0);
        chk("arst_illegal", {31'd0, bus_if.out_illegal}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        bus_if.out_ready = 1'b1;
        offer(32'h00221820, 32'd5, 32'd7);
        step();
        bus_if.in_valid = 1'b0;
        chk("post_valid", {31'd0, bus_if.out_valid}, 32'd1);
        chk("post_control", {20'd0, bus_if.out_alu_control}, 32'h800);
        chk("post_src1", bus_if.out_alu_src1, 32'd5);
        chk("post_src2", bus_if.out_alu_src2, 32'd7);
        chk("post_wen", {31'd0, bus_if.out_wen}, 32'd1);
        step();
        chk("post_empty", {31'd0, bus_if.out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_decode.md
# alu_issue_decode

Producer side of the one-hot 12-bit ALU control interface. Accepts MIPS integer instructions with their register operands over a valid/ready handshake. Decodes each into a one-hot `alu_control` vector, the selected `alu_src1`/`alu_src2` operands and writeback information. Registers the result into a 2-entry skid buffer, so the ALU stage can stall without losing instructions. It sits between register read and the ALU in the lab CPU datapath.

## Interface
- No parameters.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `in_valid` in 1: instruction and operands valid.
- `in_ready` out 1: block can accept; transfer when `in_valid && in_ready`.
- `in_inst` in 32: MIPS instruction word.
- `in_rs_value` in 32: value of register rs.
- `in_rt_value` in 32: value of register rt.
- `out_valid` out 1: decoded entry valid.
- `out_ready` in 1: ALU stage accepts; transfer when `out_valid && out_ready`.
- `out_alu_control` out 12: one-hot, bit 11..0 = add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
- `out_alu_src1` out 32: first ALU operand (shift amount for shifts).
- `out_alu_src2` out 32: second ALU operand.
- `out_dest` out 5: destination register.
- `out_wen` out 1: register write enable.
- `out_illegal` out 1: instruction not an ALU instruction.
- `illegal_count` out 16: saturating count of accepted illegal instructions.

## Operation
- R-type (opcode 0), selected by funct:
  - `20`/`21` → add, `22`/`23` → sub, `2A` → slt, `2B` → sltu.
  - `24` → and, `27` → nor, `25` → or, `26` → xor.
  - `00` → sll, `02` → srl, `03` → sra.
  - Operands: src1 = rs value, src2 = rt value, dest = rd.
  - For `00`/`02`/`03` only: src1 = {27'b0, shamt}.
- I-type, selected by opcode; dest = rt, src1 = rs value:
  - `08`/`09` → add, `0A` → slt, `0B` → sltu, with src2 = sign-extended imm16.
  - `0C` → and, `0D` → or, `0E` → xor, with src2 = zero-extended imm16.
  - `0F` → lui, with src2 = {16'b0, imm16}.
- `out_wen` = 1 when dest ≠ 0, else 0. NOP (0x00000000) decodes as sll with `out_wen` = 0.
- Any other encoding: `out_alu_control` = 0, `out_wen` = 0, `out_illegal` = 1, src1/src2 = 0, dest = 0.
- `out_alu_control` is exactly one-hot for legal instructions and all-zero for illegal ones.
- `illegal_count` increments by 1 on each accepted illegal instruction and saturates at 0xFFFF.

## Timing
- Buffer state machine:
  - States: EMPTY, ONE, TWO (entries held). Reset → EMPTY.
  - EMPTY + accept → ONE.
  - ONE + accept without pop → TWO. ONE + pop without accept → EMPTY. ONE + accept and pop → ONE.
  - TWO + pop → ONE. No accept is possible in TWO.
- `in_ready` is registered and equals (state ≠ TWO). It is a function of state only, never combinational on `out_ready`.
- Latency: accept in cycle N → `out_valid` in cycle N+1, with decode done before the register.
- Throughput: 1 instruction per cycle while `out_ready` = 1.
- Ordering is strictly FIFO. The output entry is always the older one.
- While `out_valid && !out_ready`, all `out_*` signals hold stable.
- Simultaneous accept and pop in ONE: the new entry becomes the output the next cycle.
- Reset values (asynchronous, mid-operation included):
  - `out_valid` = 0, `in_ready` = 1, `illegal_count` = 0.
  - All other outputs = 0. Buffered entries are discarded.
- Inputs are ignored while `resetn` = 0.

## Configuration
- Macro: `ALU_DECODE_VARSHIFT_EN`.
- Defined: R-type funct `04` → sll, `06` → srl, `07` → srav as sra, each with src1 = {27'b0, rs_value[4:0]}, src2 = rt value, dest = rd.
- Undefined: funct `04`/`06`/`07` are illegal.

## Structure
- Shared package `alu_defs` holds:
  - One-hot bit-index constants ALU_ADD_BIT…ALU_LUI_BIT (11..0).
  - Opcode and funct constants.
  - Typedef `alu_issue_t` {control, src1, src2, dest, wen, illegal} of 83 bits.
- One sub-module `alu_op_decoder`: purely combinational decode from (inst, rs, rt) to `alu_issue_t`. The top level owns the skid buffer, state machine and counter.

## Test plan
- `add $3,$1,$2` (0x00221820), rs=5, rt=7, `out_ready`=1 → next cycle control 0x800, src1 5, src2 7, dest 3, wen 1.
- `addiu $2,$1,-1` (0x2422FFFF) → control 0x800, src2 0xFFFFFFFF. `ori $2,$1,0x8000` (0x34228000) → control 0x020, src2 0x00008000.
- `sll $4,$2,3` (0x000220C0), rt=0x10 → control 0x008, src1 3, src2 0x10, dest 4. `lui` (opcode 0x0F, imm 0x1234) → control 0x001, src2 0x00001234.
- Backpressure: `out_ready`=0, offer 3 back-to-back instructions A, B, C → A and B accepted and `in_ready`=0 from cycle 2. Raise `out_ready` → A, B, C emerge in order, with output stable during the stall.
- Illegal 0xFC000000 → `out_illegal`=1, control 0, wen 0, `illegal_count` 0→1. Funct 0x04 → illegal only when `ALU_DECODE_VARSHIFT_EN` is undefined.
- Assert `resetn`=0 with state TWO → `out_valid`=0, `in_ready`=1 and `illegal_count`=0 immediately (asynchronous). First instruction after release decodes normally.
